vec_strided_mem_master: RTL and testbench

- Memory-side initiator for the vector coprocessor. Executes one strided load or store command as a sequence of single-word requests on the native valid/ready memory bus.
- Load elements are returned as a valid/ready stream; store elements are consumed from a valid/ready stream.
- Sits between the vector decode/register-file logic and the shared memory responder.

---
 rtl/vec_mem_pkg.sv | 34 +++
 rtl/vec_lane_align.sv | 50 +++++
 rtl/vec_strided_mem_master.sv | 185 ++++++++++++++++++
 tb/tb_vec_strided_mem_master.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_mem_pkg.sv
// Shared definitions for the strided vector memory master: SEW encodings,
// FSM state enum, per-SEW strobe patterns and the misalignment predicate.
package vec_mem_pkg;

    localparam logic [1:0] SEW_8  = 2'b00;
    localparam logic [1:0] SEW_16 = 2'b01;
    localparam logic [1:0] SEW_32 = 2'b10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        REQ   = 3'd2,
        RESP  = 3'd3,
        NEXT  = 3'd4,
        DONE  = 3'd5
    } state_e;

    // Strobe patterns before shifting into the addressed lane
    localparam logic [3:0] STRB_8  = 4'b0001;
    localparam logic [3:0] STRB_16 = 4'b0011;
    localparam logic [3:0] STRB_32 = 4'b1111;

    // An element is misaligned when its byte offset is not a multiple of its size
    function automatic logic lane_misaligned(input logic [1:0] sew, input logic [1:0] off);
        logic bad;
        case (sew)
            SEW_8:   bad = 1'b0;
            SEW_16:  bad = off[0];
            default: bad = (off != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/vec_lane_align.sv
// Combinational lane steering: extracts/masks a load element from a memory
// word and shifts/strobes a store element into its byte lanes. Low offset
// bits below the element size are ignored (16b drops off[0], 32b drops both).
module vec_lane_align
    import vec_mem_pkg::*;
(
    input  logic [1:0]  sew,
    input  logic [1:0]  off,
    input  logic [31:0] rdata,
    input  logic [31:0] st_data,
    output logic [31:0] ld_lane,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb
);

    logic [31:0] mask;
    logic [3:0]  strb;
    logic [1:0]  eff_off;
    logic [4:0]  shamt;

    // Select element mask, base strobe and effective lane offset from SEW
    always_comb begin
        mask    = 32'hFFFF_FFFF;
        strb    = STRB_32;
        eff_off = 2'b00;
        case (sew)
            SEW_8: begin
                mask    = 32'h0000_00FF;
                strb    = STRB_8;
                eff_off = off;
            end
            SEW_16: begin
                mask    = 32'h0000_FFFF;
                strb    = STRB_16;
                eff_off = {off[1], 1'b0};
            end
            default: begin
                mask    = 32'hFFFF_FFFF;
                strb    = STRB_32;
                eff_off = 2'b00;
            end
        endcase
    end

    assign shamt   = {eff_off, 3'b000};
    assign ld_lane = (rdata >> shamt) & mask;
    assign wdata   = (st_data & mask) << shamt;
    assign wstrb   = strb << eff_off;

endmodule

// File: rtl/vec_strided_mem_master.sv
// Strided vector load/store master: runs one command as a sequence of
// single-word requests on the valid/ready memory bus, streaming load
// elements out and store elements in.
// Optional macro VEC_MISALIGN_TRAP_EN: abort with err on misaligned 16b/32b
// elements instead of silently ignoring the low address bits.
module vec_strided_mem_master
    import vec_mem_pkg::*;
#(
    parameter int VL_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_store,
    input  logic [31:0]     cmd_base,
    input  logic [31:0]     cmd_stride,
    input  logic [VL_W-1:0] cmd_vl,
    input  logic [1:0]      cmd_sew,
    output logic            ld_valid,
    output logic [31:0]     ld_data,
    input  logic            ld_ready,
    input  logic            st_valid,
    input  logic [31:0]     st_data,
    output logic            st_ready,
    output logic            done,
    output logic            err,
    output logic            busy,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic [31:0]     mem_addr,
    output logic [31:0]     mem_wdata,
    output logic [3:0]      mem_wstrb,
    input  logic [31:0]     mem_rdata
);

    state_e          state;
    logic            store_q;
    logic [1:0]      sew_q;
    logic [31:0]     stride_q;
    logic [31:0]     addr_q;
    logic [VL_W-1:0] cnt;
    logic [31:0]     next_addr;
    logic [31:0]     lane_ld;
    logic [31:0]     lane_wdata;
    logic [3:0]      lane_wstrb;
    logic            trap_start;
    logic            trap_fetch;
    logic            trap_next;

    assign next_addr = addr_q + stride_q;

    // Lane steering always works from the current element address
    vec_lane_align u_align (
        .sew     (sew_q),
        .off     (addr_q[1:0]),
        .rdata   (mem_rdata),
        .st_data (st_data),
        .ld_lane (lane_ld),
        .wdata   (lane_wdata),
        .wstrb   (lane_wstrb)
    );

`ifdef VEC_MISALIGN_TRAP_EN
    logic trap_take;
    logic err_q;

    // Misalignment is judged on the address about to enter REQ
    assign trap_start = lane_misaligned(cmd_sew, cmd_base[1:0]);
    assign trap_fetch = lane_misaligned(sew_q, addr_q[1:0]);
    assign trap_next  = lane_misaligned(sew_q, next_addr[1:0]);

    assign trap_take = (state == IDLE  && cmd_valid && cmd_vl != '0 && !cmd_store && trap_start)
                    || (state == FETCH && st_valid && trap_fetch)
                    || (state == NEXT  && cnt != VL_W'(1) && !store_q && trap_next);

    // err is high exactly in the DONE cycle reached through a trap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= trap_take;
    end

    assign err = err_q;
`else
    assign trap_start = 1'b0;
    assign trap_fetch = 1'b0;
    assign trap_next  = 1'b0;
    assign err        = 1'b0;
`endif

    // Command sequencer: one memory request per element, strobe/data set on REQ entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            store_q   <= 1'b0;
            sew_q     <= SEW_8;
            stride_q  <= '0;
            addr_q    <= '0;
            cnt       <= '0;
            ld_data   <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        store_q  <= cmd_store;
                        sew_q    <= cmd_sew;
                        stride_q <= cmd_stride;
                        addr_q   <= cmd_base;
                        cnt      <= cmd_vl;
                        if (cmd_vl == '0) begin
                            state <= DONE;
                        end else if (cmd_store) begin
                            state <= FETCH;
                        end else if (trap_start) begin
                            state <= DONE;
                        end else begin
                            state     <= REQ;
                            mem_addr  <= {cmd_base[31:2], 2'b00};
                            mem_wdata <= '0;
                            mem_wstrb <= '0;
                        end
                    end
                end
                FETCH: begin
                    if (st_valid) begin
                        if (trap_fetch) begin
                            state <= DONE;
                        end else begin
                            state     <= REQ;
                            mem_addr  <= {addr_q[31:2], 2'b00};
                            mem_wdata <= lane_wdata;
                            mem_wstrb <= lane_wstrb;
                        end
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        if (store_q) begin
                            state <= NEXT;
                        end else begin
                            ld_data <= lane_ld;
                            state   <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (ld_ready) state <= NEXT;
                end
                NEXT: begin
                    addr_q <= next_addr;
                    cnt    <= cnt - VL_W'(1);
                    if (cnt == VL_W'(1)) begin
                        state <= DONE;
                    end else if (store_q) begin
                        state <= FETCH;
                    end else if (trap_next) begin
                        state <= DONE;
                    end else begin
                        state     <= REQ;
                        mem_addr  <= {next_addr[31:2], 2'b00};
                        mem_wdata <= '0;
                        mem_wstrb <= '0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE) && (state != DONE);
    assign st_ready  = (state == FETCH);
    assign mem_valid = (state == REQ);
    assign ld_valid  = (state == RESP);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_vec_strided_mem_master.sv
// Self-checking bench for vec_strided_mem_master: element-level reference
// model, randomized memory responder / stream endpoints, directed cases.
module tb_vec_strided_mem_master;

    localparam int VL_W = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            cmd_valid, cmd_ready, cmd_store;
    logic [31:0]     cmd_base, cmd_stride;
    logic [VL_W-1:0] cmd_vl;
    logic [1:0]      cmd_sew;
    logic            ld_valid, ld_ready, st_valid, st_ready;
    logic [31:0]     ld_data, st_data;
    logic            done, err, busy;
    logic            mem_valid, mem_ready;
    logic [31:0]     mem_addr, mem_wdata, mem_rdata;
    logic [3:0]      mem_wstrb;

    vec_strided_mem_master #(.VL_W(VL_W)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_store(cmd_store),
        .cmd_base(cmd_base), .cmd_stride(cmd_stride), .cmd_vl(cmd_vl), .cmd_sew(cmd_sew),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .st_valid(st_valid), .st_data(st_data), .st_ready(st_ready),
        .done(done), .err(err), .busy(busy),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } req_t;

    req_t        exp_req[$];
    req_t        got_req[$];
    logic [31:0] exp_ld[$];
    logic [31:0] got_ld[$];
    logic [31:0] st_vals[$];
    logic [31:0] bus_mem[logic [31:0]];
    logic [31:0] ref_mem[logic [31:0]];

    int n_tests = 0;
    int n_fail  = 0;
    int st_idx = 0;
    int done_cnt = 0;
    int ld_hold = 0;
    int first_run = -1;
    bit exp_active = 0;
    bit exp_err = 0;
    bit last_err = 0;
    bit mem_stall = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic [31:0] dflt(input logic [31:0] w);
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] bus_rd(input logic [31:0] w);
        return bus_mem.exists(w) ? bus_mem[w] : dflt(w);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] w);
        return ref_mem.exists(w) ? ref_mem[w] : dflt(w);
    endfunction

    function automatic logic [31:0] byte_mask(input logic [3:0] s);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{s[b]}};
        return m;
    endfunction

    // Reference model: element i lives at base + i*stride; the element is a
    // naturally aligned 1/2/4-byte field inside its word.
    task automatic model_cmd(input bit st, input logic [31:0] base, input logic [31:0] stride,
                             input int vl, input logic [1:0] sew);
        int          size;
        int          lane;
        logic [31:0] a, w, d, word;
        logic [63:0] m64;
        logic [31:0] mask;
        logic [3:0]  strb;
        size = (sew == 2'd0) ? 1 : (sew == 2'd1) ? 2 : 4;
        m64  = (64'd1 << (8 * size)) - 64'd1;
        mask = m64[31:0];
        exp_err = 0;
        for (int i = 0; i < vl; i++) begin
            a = base + stride * 32'(i);
`ifdef VEC_MISALIGN_TRAP_EN
            if ((a % size) != 0) begin
                exp_err = 1;
                break;
            end
`endif
            lane = ((int'(a % 4)) / size) * size;
            w    = a & ~32'd3;
            if (st) begin
                d    = st_vals[i];
                strb = 4'(((1 << size) - 1) << lane);
                exp_req.push_back('{addr: w, wdata: (d & mask) << (8 * lane), strb: strb});
                word = ref_rd(w >> 2);
                word = (word & ~byte_mask(strb)) | (((d & mask) << (8 * lane)) & byte_mask(strb));
                ref_mem[w >> 2] = word;
            end else begin
                exp_req.push_back('{addr: w, wdata: 32'd0, strb: 4'd0});
                exp_ld.push_back((ref_rd(w >> 2) >> (8 * lane)) & mask);
            end
        end
    endtask

    // Environment + compare process: checks DUT outputs every cycle against
    // the model, then drives the memory responder and stream endpoints.
    initial begin : bus
        int   resp_wait;
        int   ld_run;
        bit   prev_ready, prev_rd, ld_take_next;
        req_t e;
        logic [31:0] w;
        resp_wait = -1; ld_run = 0; prev_ready = 0; prev_rd = 0; ld_take_next = 0;
        mem_ready = 0; mem_rdata = 0; st_valid = 0; st_data = 0; ld_ready = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                mem_ready = 0; st_valid = 0; ld_ready = 0;
                resp_wait = -1; prev_ready = 0; prev_rd = 0; ld_run = 0; ld_take_next = 0;
            end else begin
                if (prev_ready) chk("valid_after_ready", 32'(mem_valid), 0);
                if (prev_rd)    chk("ld_valid_latency", 32'(ld_valid), 1);
                if (busy)       chk("cmd_ready_while_busy", 32'(cmd_ready), 0);
                if (mem_valid) begin
                    if (exp_req.size() == 0) chk("unexpected_req", 1, 0);
                    else begin
                        e = exp_req[0];
                        chk("mem_addr", mem_addr, e.addr);
                        chk("mem_wstrb", 32'(mem_wstrb), 32'(e.strb));
                        chk("mem_wdata", mem_wdata & byte_mask(e.strb), e.wdata & byte_mask(e.strb));
                    end
                end
                if (ld_valid) begin
                    chk("mem_valid_during_ld", 32'(mem_valid), 0);
                    if (exp_ld.size() == 0) chk("unexpected_ld", 1, 0);
                    else chk("ld_data", ld_data, exp_ld[0]);
                end
                if (done) begin
                    chk("done_expected", 32'(exp_active), 1);
                    chk("req_left", exp_req.size(), 0);
                    chk("ld_left", exp_ld.size(), 0);
                    chk("err", 32'(err), 32'(exp_err));
                    last_err = err;
                    exp_active = 0;
                    done_cnt++;
                end else if (err) begin
                    chk("err_without_done", 1, 0);
                end

                prev_ready = 0; prev_rd = 0; mem_ready = 0; mem_rdata = $urandom;
                if (mem_valid) begin
                    if (resp_wait < 0) resp_wait = mem_stall ? (1 << 30) : int'($urandom_range(0, 3));
                    if (resp_wait == 0) begin
                        mem_ready = 1; prev_ready = 1; resp_wait = -1;
                        if (mem_wstrb == 4'd0) begin
                            mem_rdata = bus_rd(mem_addr >> 2);
                            prev_rd = 1;
                        end else begin
                            w = bus_rd(mem_addr >> 2);
                            w = (w & ~byte_mask(mem_wstrb)) | (mem_wdata & byte_mask(mem_wstrb));
                            bus_mem[mem_addr >> 2] = w;
                        end
                        got_req.push_back('{addr: mem_addr, wdata: mem_wdata, strb: mem_wstrb});
                        if (exp_req.size() > 0) void'(exp_req.pop_front());
                    end else begin
                        resp_wait--;
                    end
                end
                ld_ready = 0;
                if (ld_valid) begin
                    ld_run++;
                    if (ld_hold > 0) begin
                        ld_hold--;
                        if (ld_hold == 0) ld_take_next = 1;
                    end else if (ld_take_next) begin
                        ld_ready = 1; ld_take_next = 0;
                    end else begin
                        ld_ready = ($urandom_range(0, 3) != 0);
                    end
                    if (ld_ready) begin
                        got_ld.push_back(ld_data);
                        if (exp_ld.size() > 0) void'(exp_ld.pop_front());
                        if (first_run < 0) first_run = ld_run;
                        ld_run = 0;
                    end
                end
                st_valid = ($urandom_range(0, 3) != 0) && (st_idx < st_vals.size());
                st_data  = (st_idx < st_vals.size()) ? st_vals[st_idx] : $urandom;
                if (st_valid && st_ready) st_idx++;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_model();
        exp_req.delete(); exp_ld.delete(); st_vals.delete();
        exp_active = 0; mem_stall = 0; ld_hold = 0;
    endtask

    task automatic run_cmd(input bit st, input logic [31:0] base, input logic [31:0] stride,
                           input int vl, input logic [1:0] sew, output int lat, output bit acc_mv);
        int k;
        while (st_vals.size() < vl) st_vals.push_back($urandom);
        st_idx = 0; first_run = -1;
        got_ld.delete(); got_req.delete();
        model_cmd(st, base, stride, vl, sew);
        exp_active = 1;
        cmd_store = st; cmd_base = base; cmd_stride = stride;
        cmd_vl = VL_W'(vl); cmd_sew = sew; cmd_valid = 1;
        chk("cmd_ready_idle", 32'(cmd_ready), 1);
        step();
        cmd_valid = 0;
        acc_mv = mem_valid;
        k = 1;
        while (!done && k < 3000) begin
            step();
            k++;
        end
        lat = k;
        if (!done) begin
            chk("done_timeout", 0, 1);
            reset = 1; step(); clear_model(); reset = 0;
        end
        step();
        st_vals.delete();
    endtask

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          lat;
        bit          mv;
        bit          st;
        logic [1:0]  sew;
        logic [31:0] base, stride;
        int          vl;

        reset = 1; cmd_valid = 0; cmd_store = 0; cmd_base = 0; cmd_stride = 0;
        cmd_vl = '0; cmd_sew = 0;
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_mem_valid", 32'(mem_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ld_valid", 32'(ld_valid), 0);
        chk("rst_st_ready", 32'(st_ready), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_wstrb", 32'(mem_wstrb), 0);
        chk("rst_ld_data", ld_data, 0);
        step(); step();
        reset = 0;
        step();

        // Load bytes 1,2,3,4 from one word
        bus_mem[100] = 32'h0403_0201; ref_mem[100] = 32'h0403_0201;
        run_cmd(0, 32'd400, 32'd1, 4, 2'd0, lat, mv);
        chk("d1_accept_to_req", 32'(mv), 1);
        chk("d1_nreq", got_req.size(), 4);
        chk("d1_nld", got_ld.size(), 4);
        if (got_ld.size() == 4 && got_req.size() == 4)
            for (int i = 0; i < 4; i++) begin
                chk("d1_ld", got_ld[i], 32'(i + 1));
                chk("d1_addr", got_req[i].addr, 32'd400);
                chk("d1_strb", 32'(got_req[i].strb), 0);
            end

        // Store two bytes at stride 4
        st_vals.push_back(32'h0000_00AA); st_vals.push_back(32'h0000_0055);
        run_cmd(1, 32'd436, 32'd4, 2, 2'd0, lat, mv);
        chk("d2_nreq", got_req.size(), 2);
        if (got_req.size() == 2) begin
            chk("d2_addr0", got_req[0].addr, 32'd436);
            chk("d2_strb0", 32'(got_req[0].strb), 32'h1);
            chk("d2_data0", 32'(got_req[0].wdata[7:0]), 32'hAA);
            chk("d2_addr1", got_req[1].addr, 32'd440);
            chk("d2_strb1", 32'(got_req[1].strb), 32'h1);
            chk("d2_data1", 32'(got_req[1].wdata[7:0]), 32'h55);
        end

        // 16b load, upper half, stride 0
        run_cmd(0, 32'd402, 32'd0, 3, 2'd1, lat, mv);
        chk("d3_nld", got_ld.size(), 3);
        if (got_ld.size() == 3 && got_req.size() == 3)
            for (int i = 0; i < 3; i++) begin
                chk("d3_ld", got_ld[i], 32'h0403);
                chk("d3_addr", got_req[i].addr, 32'd400);
            end

        // Consumer stalls the first element for 5 cycles
        ld_hold = 5;
        run_cmd(0, 32'h2000, 32'd4, 2, 2'd2, lat, mv);
        chk("d4_ld_valid_cycles", first_run, 6);

        // Reset while a request is outstanding
        mem_stall = 1; st_idx = 0;
        model_cmd(0, 32'h3000, 32'd4, 3, 2'd2);
        exp_active = 1;
        cmd_store = 0; cmd_base = 32'h3000; cmd_stride = 32'd4; cmd_vl = VL_W'(3);
        cmd_sew = 2'd2; cmd_valid = 1;
        step();
        cmd_valid = 0;
        chk("d5_in_req", 32'(mem_valid), 1);
        step(); step();
        reset = 1;
        #1;
        chk("d5_rst_mem_valid", 32'(mem_valid), 0);
        chk("d5_rst_busy", 32'(busy), 0);
        chk("d5_rst_cmd_ready", 32'(cmd_ready), 1);
        clear_model();
        step();
        reset = 0;
        step();
        run_cmd(0, 32'h3000, 32'd4, 0, 2'd2, lat, mv);
        chk("d5_vl0_latency_ok", 32'(lat == 1 || lat == 2), 1);
        chk("d5_vl0_nreq", got_req.size(), 0);

`ifdef VEC_MISALIGN_TRAP_EN
        // Misaligned 32b load traps before any request
        run_cmd(0, 32'd401, 32'd4, 3, 2'd2, lat, mv);
        chk("d6_nreq", got_req.size(), 0);
        chk("d6_err", 32'(last_err), 1);
`endif

        // Randomized commands against the model
        for (int t = 0; t < 60; t++) begin
            st  = bit'($urandom_range(0, 1));
            sew = 2'($urandom_range(0, 3));
            vl  = int'($urandom_range(0, 10));
            if ($urandom_range(0, 7) == 0) base = 32'hFFFF_FFF0 + $urandom_range(0, 15);
            else                           base = 32'h1000 + $urandom_range(0, 63);
            case ($urandom_range(0, 5))
                0:       stride = 32'd0;
                1:       stride = $urandom_range(1, 8);
                2:       stride = -$urandom_range(1, 8);
                3:       stride = 4 * $urandom_range(1, 4);
                4:       stride = -(4 * $urandom_range(1, 4));
                default: stride = $urandom_range(0, 3) << sew;
            endcase
            run_cmd(st, base, stride, vl, sew, lat, mv);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
